// File: rtl/dac_test_pkg.sv
// Shared definitions for the DAC test pattern generator and its checkers:
// pattern/state enums, LFSR polynomial, default seed and the LFSR step function.
package dac_test_pkg;

   typedef enum logic [1:0] {
      PAT_CONST = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_PRBS  = 2'd2,
      PAT_TRI   = 2'd3
   } pat_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } gen_state_e;

   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

   // Right-shifting Galois form of x^32+x^22+x^2+x+1
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/dac_pattern_gen_if.sv
// Valid/ready sample stream between the pattern generator and the DAC path.
interface dac_pattern_gen_if #(
   parameter int DATA_W = 16
) ();
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/dac_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance enable; shared by
// the transmit generator and receive-side checkers.
module dac_lfsr32
   import dac_test_pkg::*;
#(
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        adv_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load_i)
         state_d = SEED;
      else if (adv_i)
         state_d = lfsr_next(state_q);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= SEED;
      else
         state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/dac_pattern_gen.sv
// DAC test pattern generator: constant/ramp/PRBS/triangle bursts on a valid/ready stream.
// Optional running checksum enabled by defining DAC_PATTERN_GEN_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start, outputs hold last burst results
// RUN     | presenting samples, out_valid high
// DONE    | one-cycle done pulse, then IDLE
module dac_pattern_gen
   import dac_test_pkg::*;
#(
   parameter int          DATA_W = 16,
   parameter int          LEN_W  = 32,
   parameter logic [31:0] SEED   = DEFAULT_SEED
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [1:0]           mode,
   input  logic [DATA_W-1:0]    step,
   input  logic [DATA_W-1:0]    const_val,
   input  logic [LEN_W-1:0]     burst_len,
   dac_pattern_gen_if.master    dac,
   output logic                 busy,
   output logic                 done,
   output logic [LEN_W-1:0]     sent_count,
   output logic [31:0]          checksum
);

   localparam logic [DATA_W-1:0] MAX_VAL = '1;

   gen_state_e        state_q, state_d;
   pat_mode_e         mode_q, mode_in;
   logic [DATA_W-1:0] step_q, data_q, next_data;
   logic              dir_down_q, next_dir;
   logic [LEN_W-1:0]  len_q, sent_q;
   logic [31:0]       lfsr_state;
   logic [DATA_W:0]   up_sum;
   logic              xfer, start_ok, last_xfer;

   assign mode_in   = pat_mode_e'(mode);
   assign xfer      = dac.out_valid && dac.out_ready;
   assign start_ok  = (state_q == ST_IDLE) && start;
   assign last_xfer = xfer && (len_q != '0) && ((sent_q + LEN_W'(1)) == len_q);
   assign up_sum    = {1'b0, data_q} + {1'b0, step_q};

   dac_lfsr32 #(.SEED(SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load_i  (start_ok),
      .adv_i   (xfer),
      .state_o (lfsr_state)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (stop || last_xfer) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dac.out_valid = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            dac.out_valid = 1'b1;
            busy          = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Triangle turns on reaching an endpoint so each endpoint appears once per turn
   always_comb begin
      next_data = data_q;
      next_dir  = dir_down_q;
      unique case (mode_q)
         PAT_CONST: next_data = data_q;
         PAT_RAMP:  next_data = data_q + step_q;
         PAT_PRBS:  next_data = DATA_W'(lfsr_next(lfsr_state));
         PAT_TRI: begin
            if (!dir_down_q) begin
               if (up_sum >= {1'b0, MAX_VAL}) begin
                  next_data = MAX_VAL;
                  next_dir  = 1'b1;
               end else begin
                  next_data = up_sum[DATA_W-1:0];
               end
            end else begin
               if (data_q <= step_q) begin
                  next_data = '0;
                  next_dir  = 1'b0;
               end else begin
                  next_data = data_q - step_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= PAT_CONST;
         step_q     <= '0;
         data_q     <= '0;
         dir_down_q <= 1'b0;
         len_q      <= '0;
         sent_q     <= '0;
      end else if (start_ok) begin
         mode_q     <= mode_in;
         step_q     <= step;
         len_q      <= burst_len;
         dir_down_q <= 1'b0;
         sent_q     <= '0;
         data_q     <= (mode_in == PAT_PRBS) ? SEED[DATA_W-1:0] : const_val;
      end else if (xfer) begin
         data_q     <= next_data;
         dir_down_q <= next_dir;
         if (sent_q != '1)
            sent_q <= sent_q + LEN_W'(1);
      end
   end

   assign dac.out_data = data_q;
   assign sent_count   = sent_q;

`ifdef DAC_PATTERN_GEN_CHECKSUM_EN
   logic [31:0] csum_q;

   always_ff @(posedge clk) begin
      if (rst)
         csum_q <= '0;
      else if (start_ok)
         csum_q <= '0;
      else if (xfer)
         csum_q <= {csum_q[30:0], csum_q[31]} ^ 32'(data_q);
   end

   assign checksum = csum_q;
`else
   assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_dac_pattern_gen.sv
// Directed bench for dac_pattern_gen: ramp, backpressure, PRBS, triangle (4-bit), abort, reset.
`timescale 1ns/1ps
module tb_dac_pattern_gen;
   import dac_test_pkg::*;

   localparam logic [31:0] TB_SEED = 32'hACE1_0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, stop;
   logic [1:0]  mode;
   logic [15:0] step, const_val;
   logic [31:0] burst_len;
   logic        busy, done;
   logic [31:0] sent_count, checksum;

   logic        start2, stop2;
   logic [1:0]  mode2;
   logic [3:0]  step2, cval2;
   logic [7:0]  len2;
   logic        busy2, done2;
   logic [7:0]  sent2;
   logic [31:0] csum2;

   dac_pattern_gen_if #(.DATA_W(16)) dac_a ();
   dac_pattern_gen_if #(.DATA_W(4))  dac_b ();

   dac_pattern_gen #(.DATA_W(16), .LEN_W(32), .SEED(TB_SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .step(step),
      .const_val(const_val), .burst_len(burst_len), .dac(dac_a), .busy(busy), .done(done),
      .sent_count(sent_count), .checksum(checksum)
   );

   dac_pattern_gen #(.DATA_W(4), .LEN_W(8), .SEED(TB_SEED)) dut_tri (
      .clk(clk), .rst(rst), .start(start2), .stop(stop2), .mode(mode2), .step(step2),
      .const_val(cval2), .burst_len(len2), .dac(dac_b), .busy(busy2), .done(done2),
      .sent_count(sent2), .checksum(csum2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] s);
      logic [31:0] r;
      r = {1'b0, s[31:1]};
      if (s[0]) r = r ^ 32'h8020_0003;
      return r;
   endfunction

   logic [15:0] got_q[$];
   int done_cnt, done_cyc, last_xfer_cyc, stall_err;

   task automatic start_burst(input logic [1:0] m, input logic [15:0] st,
                              input logic [15:0] cv, input logic [31:0] len);
      mode = m; step = st; const_val = cv; burst_len = len;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // rdy_mode 0: always ready; 1: ready toggles starting low
   task automatic run_collect(input int rdy_mode, input int budget);
      logic        held_v;
      logic [15:0] held_d;
      got_q.delete();
      done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1; stall_err = 0;
      held_v = 1'b0; held_d = '0;
      for (int c = 0; c < budget; c++) begin
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (held_v && !(dac_a.out_valid && dac_a.out_data == held_d)) stall_err++;
         dac_a.out_ready = (rdy_mode == 0) ? 1'b1 : c[0];
         if (dac_a.out_valid && dac_a.out_ready) begin
            got_q.push_back(dac_a.out_data);
            last_xfer_cyc = c;
         end
         held_v = dac_a.out_valid && !dac_a.out_ready;
         held_d = dac_a.out_data;
         @(negedge clk);
         if (done_cnt > 0 && c >= done_cyc + 2) break;
      end
      dac_a.out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] exp16[4];
      logic [3:0]  tri_exp[8];
      logic [3:0]  tri_q[$];
      logic [31:0] lf, csum_m, seed_v;
      logic [15:0] e;
      int          mism, n, guard, done_seen;

      rst = 1'b1; start = 0; stop = 0; mode = 0; step = 0; const_val = 0; burst_len = 0;
      start2 = 0; stop2 = 0; mode2 = 0; step2 = 0; cval2 = 0; len2 = 0;
      dac_a.out_ready = 1'b0; dac_b.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, dac_a.out_valid}, 32'd0);
      check("rst_data", {16'd0, dac_a.out_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sent", sent_count, 32'd0);
      check("rst_csum", checksum, 32'd0);
      check("rst_tri_valid", {31'd0, dac_b.out_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Ramp wrapping through zero
      start_burst(2'd1, 16'd1, 16'hFFFE, 32'd4);
      run_collect(0, 30);
      exp16 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      check("ramp_count", got_q.size(), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("ramp_s%0d", i), {16'd0, got_q[i]}, {16'd0, exp16[i]});
      check("ramp_sent", sent_count, 32'd4);
      check("ramp_done_cnt", done_cnt, 32'd1);
      check("ramp_done_lat", done_cyc, last_xfer_cyc + 1);

      // Backpressure
      start_burst(2'd1, 16'd3, 16'd0, 32'd3);
      run_collect(1, 40);
      check("bp_count", got_q.size(), 32'd3);
      for (int i = 0; i < 3; i++) check($sformatf("bp_s%0d", i), {16'd0, got_q[i]}, 32'(i * 3));
      check("bp_stall", stall_err, 32'd0);
      check("bp_sent", sent_count, 32'd3);
      check("bp_done_cnt", done_cnt, 32'd1);

      // PRBS 1000 samples against the bench model
      start_burst(2'd2, 16'd0, 16'd0, 32'd1000);
      run_collect(0, 2200);
      seed_v = TB_SEED;
      check("prbs_count", got_q.size(), 32'd1000);
      check("prbs_first", {16'd0, got_q[0]}, {16'd0, seed_v[15:0]});
      lf = TB_SEED; csum_m = '0; mism = 0;
      for (int i = 0; i < 1000; i++) begin
         e = lf[15:0];
         if (got_q[i] !== e) mism++;
         csum_m = {csum_m[30:0], csum_m[31]} ^ {16'd0, e};
         lf = model_next(lf);
      end
      check("prbs_mismatches", mism, 32'd0);
      check("prbs_sent", sent_count, 32'd1000);
`ifdef DAC_PATTERN_GEN_CHECKSUM_EN
      check("prbs_csum", checksum, csum_m);
`else
      check("prbs_csum", checksum, 32'd0);
`endif

      // Triangle on the 4-bit instance
      mode2 = 2'd3; step2 = 4'd2; cval2 = 4'd12; len2 = 8'd8; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      tri_exp = '{4'd12, 4'd14, 4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd5};
      dac_b.out_ready = 1'b1;
      for (int c = 0; c < 40 && tri_q.size() < 8; c++) begin
         if (dac_b.out_valid) tri_q.push_back(dac_b.out_data);
         @(negedge clk);
      end
      dac_b.out_ready = 1'b0;
      check("tri_count", tri_q.size(), 32'd8);
      for (int i = 0; i < 8; i++) check($sformatf("tri_s%0d", i), {28'd0, tri_q[i]}, {28'd0, tri_exp[i]});
      check("tri_sent", {24'd0, sent2}, 32'd8);
      check("tri_done", {31'd0, done2}, 32'd1);

      // Abort in infinite mode, stop coinciding with 11th transfer
      start_burst(2'd1, 16'd1, 16'd100, 32'd0);
      dac_a.out_ready = 1'b1;
      n = 0; guard = 0;
      while (n < 10 && guard < 40) begin
         if (dac_a.out_valid) n++;
         @(negedge clk);
         guard++;
      end
      check("abort_pre_valid", {31'd0, dac_a.out_valid}, 32'd1);
      check("abort_pre_data", {16'd0, dac_a.out_data}, 32'd110);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      dac_a.out_ready = 1'b0;
      check("abort_sent", sent_count, 32'd11);
      check("abort_valid", {31'd0, dac_a.out_valid}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      check("abort_done_once", {31'd0, done}, 32'd0);
      start_burst(2'd1, 16'd1, 16'd100, 32'd0);
      check("restart_data", {16'd0, dac_a.out_data}, 32'd100);
      check("restart_sent", sent_count, 32'd0);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      @(negedge clk);

      // Reset mid-burst
      start_burst(2'd1, 16'd7, 16'd9, 32'd0);
      dac_a.out_ready = 1'b1;
      guard = 0;
      while (sent_count != 32'd5 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("rstmid_reached5", sent_count, 32'd5);
      rst = 1'b1; start = 1'b1;
      done_seen = 0;
      @(negedge clk);
      if (done) done_seen++;
      check("rstmid_valid", {31'd0, dac_a.out_valid}, 32'd0);
      check("rstmid_data", {16'd0, dac_a.out_data}, 32'd0);
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_sent", sent_count, 32'd0);
      check("rstmid_csum", checksum, 32'd0);
      @(negedge clk);
      if (done) done_seen++;
      rst = 1'b0; start = 1'b0;
      dac_a.out_ready = 1'b0;
      @(negedge clk);
      if (done) done_seen++;
      check("rstmid_no_done", done_seen, 32'd0);
      check("rstmid_start_ignored", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
